// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter sharing the single register-file write port
//            between ALU/I-type writeback (req0) and load writeback (req1).
//            Registers the winner onto reg_write/wr/data, suppresses writes
//            to x0 and keeps a saturating count of contention cycles.
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int XLEN  = 64,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [AW-1:0]    req0_addr,
    input  logic [XLEN-1:0]  req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [AW-1:0]    req1_addr,
    input  logic [XLEN-1:0]  req1_data,
    output logic             reg_write,
    output logic [AW-1:0]    wr,
    output logic [XLEN-1:0]  data,
    output logic             prio,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    c_x0      = {AW{1'b0}};

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_contend;

    logic             reg_write_q, reg_write_d;
    logic [AW-1:0]    wr_q,        wr_d;
    logic [XLEN-1:0]  data_q,      data_d;
    logic             prio_q,      prio_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    // Grant decision: a lone requester wins, on contention the prio holder wins.
    // Readiness never depends on itself, only on valids, prio, hold and reset.
    always_comb begin
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_contend = req0_valid && req1_valid && !hold;
        if (!reset && !hold) begin
            w_gnt0 = req0_valid && (!req1_valid || (prio_q == 1'b0));
            w_gnt1 = req1_valid && (!req0_valid || (prio_q == 1'b1));
        end
    end

    // Next-state for the output stage, round-robin pointer and contention counter.
    always_comb begin
        reg_write_d = 1'b0;
        wr_d        = wr_q;
        data_d      = data_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        if (w_gnt0) begin
            wr_d        = req0_addr;
            data_d      = req0_data;
            reg_write_d = (req0_addr != c_x0);
            prio_d      = 1'b1;
        end else if (w_gnt1) begin
            wr_d        = req1_addr;
            data_d      = req1_data;
            reg_write_d = (req1_addr != c_x0);
            prio_d      = 1'b0;
        end
        if (w_contend && (cnt_q != c_cnt_max)) begin
            cnt_d = cnt_q + c_cnt_one;
        end
    end

    // State registers; reset discards any transfer seen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            wr_q        <= c_x0;
            data_q      <= {XLEN{1'b0}};
            prio_q      <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            reg_write_q <= reg_write_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req0_ready   = w_gnt0;
    assign req1_ready   = w_gnt1;
    assign reg_write    = reg_write_q;
    assign wr           = wr_q;
    assign data         = data_q;
    assign prio         = prio_q;
    assign conflict_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed plus randomized stimulus against a cycle-level model of
//            the write-port arbitration rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int XLEN  = 64;
    localparam int AW    = 5;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             hold;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [AW-1:0]    req0_addr, req1_addr;
    logic [XLEN-1:0]  req0_data, req1_data;
    logic             reg_write;
    logic [AW-1:0]    wr;
    logic [XLEN-1:0]  data;
    logic             prio;
    logic [CNT_W-1:0] conflict_cnt;

    regfile_write_arbiter #(.XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .reg_write    (reg_write),
        .wr           (wr),
        .data         (data),
        .prio         (prio),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file as seen through the DUT write port.
    logic [XLEN-1:0] rf_dut [32];
    always @(posedge clk) begin
        if (reg_write) rf_dut[wr] <= data;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int              m_prio;
    int              m_cnt;
    logic            m_rw;
    logic [AW-1:0]   m_wr;
    logic [XLEN-1:0] m_data;
    logic [XLEN-1:0] m_rf [32];
    logic            last_g0, last_g1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check the handshake,
    // advance the model, then check registered outputs after the rising edge.
    task automatic cycle(input logic rst, input logic hld,
                         input logic v0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        logic g0, g1;
        @(negedge clk);
        reset = rst; hold = hld;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (!rst && !hld) begin
            if (v0 && v1) begin
                g0 = (m_prio == 0);
                g1 = (m_prio == 1);
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        check("req0_ready", {63'd0, req0_ready}, {63'd0, g0});
        check("req1_ready", {63'd0, req1_ready}, {63'd0, g1});
        last_g0 = g0; last_g1 = g1;
        if (rst) begin
            m_rw = 1'b0; m_wr = '0; m_data = '0; m_prio = 0; m_cnt = 0;
        end else begin
            m_rw = 1'b0;
            if (g0 || g1) begin
                m_wr   = g0 ? a0 : a1;
                m_data = g0 ? d0 : d1;
                m_rw   = (m_wr != 0);
                if (m_rw) m_rf[m_wr] = m_data;
                m_prio = g0 ? 1 : 0;
            end
            if (v0 && v1 && !hld && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
        check("reg_write",    {63'd0, reg_write}, {63'd0, m_rw});
        check("wr",           {59'd0, wr}, {59'd0, m_wr});
        check("data",         data, m_data);
        check("prio",         {63'd0, prio}, 64'(m_prio));
        check("conflict_cnt", {61'd0, conflict_cnt}, 64'(m_cnt));
    endtask

    logic            p0v, p1v;
    logic [AW-1:0]   p0a, p1a;
    logic [XLEN-1:0] p0d, p1d;
    logic            rr, rh;

    initial begin
        reset = 1'b1; hold = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        m_prio = 0; m_cnt = 0; m_rw = 1'b0; m_wr = '0; m_data = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;

        // Reset, then a single req0 write.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 5, 64'hAB, 0, 0, 0);

        // Contention fairness from reset.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 3, 64'h11, 1, 4, 64'h22);
        cycle(0, 0, 1, 3, 64'h11, 1, 4, 64'h22);

        // x0 drop: set prio to 1 first, then a req1 write to x0.
        cycle(0, 0, 1, 9, 64'h99, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 64'hFFFF);

        // Hold for three cycles with both valid, then release.
        cycle(0, 1, 1, 10, 64'hA0, 1, 11, 64'hB0);
        cycle(0, 1, 1, 10, 64'hA0, 1, 11, 64'hB0);
        cycle(0, 1, 1, 10, 64'hA0, 1, 11, 64'hB0);
        cycle(0, 0, 1, 10, 64'hA0, 1, 11, 64'hB0);

        // Same-address collision with prio=0.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 7, 64'h1, 1, 7, 64'h2);
        cycle(0, 0, 1, 7, 64'h1, 1, 7, 64'h2);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("rf7_final", rf_dut[7], m_rf[7]);
        check("rf7_value", rf_dut[7], 64'h2);

        // Counter saturation, then reset on a grant cycle.
        for (int i = 0; i < CMAX + 3; i++) cycle(0, 0, 1, 12, 64'hC, 1, 13, 64'hD);
        cycle(1, 0, 1, 12, 64'hC, 1, 13, 64'hD);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic honouring the hold-stable requester contract.
        p0v = 1'b0; p1v = 1'b0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 99) < 3);
            rh = ($urandom_range(0, 99) < 20);
            cycle(rr, rh, p0v, p0a, p0d, p1v, p1a, p1d);
            if (!p0v || last_g0 || rr) begin
                p0v = 1'($urandom_range(0, 1));
                p0a = AW'($urandom_range(0, 7));
                p0d = {$urandom, $urandom};
            end
            if (!p1v || last_g1 || rr) begin
                p1v = 1'($urandom_range(0, 1));
                p1a = AW'($urandom_range(0, 7));
                p1d = {$urandom, $urandom};
            end
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) check("rf_final", rf_dut[i], m_rf[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
